// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use stall, flush bubbles, illegal-op tracking.
module pipe_ctrl_unit #(
    parameter int OPCODE_W = 3,
    parameter int RA_W     = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_id,
    input  logic [OPCODE_W-1:0] opcode_id,
    input  logic [RA_W-1:0]     rs_id,
    input  logic [RA_W-1:0]     rt_id,
    input  logic                flush_in,
    output logic                hazard_stall,
    output logic                ex_regDst,
    output logic                ex_aluSrc,
    output logic [1:0]          ex_aluOp,
    output logic                mem_memRead,
    output logic                mem_memWrite,
    output logic                mem_branch,
    output logic                wb_memtoReg,
    output logic                wb_regWrite,
    output logic                illegal_op,
    output logic [OPCODE_W-1:0] illegal_opcode,
    output logic [CNT_W-1:0]    illegal_cnt
);

    typedef struct packed {
        logic       regDst;
        logic       aluSrc;
        logic       memtoReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       branch;
        logic [1:0] aluOp;
    } ctrl_t;

    typedef struct packed {
        logic memtoReg;
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic branch;
    } memCtrl_t;

    typedef struct packed {
        logic memtoReg;
        logic regWrite;
    } wbCtrl_t;

    ctrl_t     idex, idexN, decWord;
    memCtrl_t  exmem, exmemN;
    wbCtrl_t   memwb, memwbN;
    logic [RA_W-1:0] idexRt, idexRtN;
    logic upperSet, isIllegal, illegalEvt;

    generate
        if (OPCODE_W > 3) begin : gUpper
            assign upperSet = |opcode_id[OPCODE_W-1:3];
        end else begin : gNoUpper
            assign upperSet = 1'b0;
        end
    endgenerate

    always_comb begin
        decWord   = '0;
        isIllegal = upperSet;
        if (!upperSet) begin
            unique case (opcode_id[2:0])
                3'b000:  decWord = 9'b100100000;
                3'b001:  decWord = 9'b010100010;
                3'b100:  decWord = 9'b011110011;
                3'b101:  decWord = 9'b010001011;
                3'b110:  decWord = 9'b000000101;
                3'b111:  decWord = 9'b010100011;
                default: isIllegal = 1'b1;
            endcase
        end
    end

    assign hazard_stall = valid_id & idex.memRead
                        & ((idexRt == rs_id) | (idexRt == rt_id))
                        & ~flush_in;

    assign illegalEvt = valid_id & isIllegal & ~flush_in & ~hazard_stall;

    always_comb begin
        idexN   = '0;
        idexRtN = '0;
        exmemN  = '{memtoReg: idex.memtoReg, regWrite: idex.regWrite,
                    memRead: idex.memRead, memWrite: idex.memWrite,
                    branch: idex.branch};
        memwbN  = '{memtoReg: exmem.memtoReg, regWrite: exmem.regWrite};
        if (flush_in) begin
            exmemN = '0;
        end else if (!hazard_stall && valid_id && !isIllegal) begin
            idexN   = decWord;
            idexRtN = rt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex   <= '0;
            idexRt <= '0;
            exmem  <= '0;
            memwb  <= '0;
        end else begin
            idex   <= idexN;
            idexRt <= idexRtN;
            exmem  <= exmemN;
            memwb  <= memwbN;
        end
    end

    // Only the first illegal opcode is kept; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op     <= 1'b0;
            illegal_opcode <= '0;
            illegal_cnt    <= '0;
        end else if (illegalEvt) begin
            if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
            if (!illegal_op) begin
                illegal_op     <= 1'b1;
                illegal_opcode <= opcode_id;
            end
        end
    end

    assign ex_regDst    = idex.regDst;
    assign ex_aluSrc    = idex.aluSrc;
    assign ex_aluOp     = idex.aluOp;
    assign mem_memRead  = exmem.memRead;
    assign mem_memWrite = exmem.memWrite;
    assign mem_branch   = exmem.branch;
    assign wb_memtoReg  = memwb.memtoReg;
    assign wb_regWrite  = memwb.regWrite;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit; a second instance with a
// 2-bit counter exercises saturation.
module tb_pipe_ctrl_unit;

    logic       clk, rst_n, valid_id, flush_in;
    logic [2:0] opcode_id, rs_id, rt_id;
    logic       hazard_stall, ex_regDst, ex_aluSrc;
    logic [1:0] ex_aluOp;
    logic       mem_memRead, mem_memWrite, mem_branch;
    logic       wb_memtoReg, wb_regWrite, illegal_op;
    logic [2:0] illegal_opcode;
    logic [7:0] illegal_cnt;

    logic       d2Stall, d2RegDst, d2AluSrc;
    logic [1:0] d2AluOp;
    logic       d2MemRead, d2MemWrite, d2Branch;
    logic       d2MemtoReg, d2RegWrite, d2IllOp;
    logic [2:0] d2IllOpc;
    logic [1:0] d2Cnt;

    pipe_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
        .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
        .flush_in(flush_in), .hazard_stall(hazard_stall),
        .ex_regDst(ex_regDst), .ex_aluSrc(ex_aluSrc),
        .ex_aluOp(ex_aluOp), .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite), .mem_branch(mem_branch),
        .wb_memtoReg(wb_memtoReg), .wb_regWrite(wb_regWrite),
        .illegal_op(illegal_op), .illegal_opcode(illegal_opcode),
        .illegal_cnt(illegal_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
        .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
        .flush_in(flush_in), .hazard_stall(d2Stall),
        .ex_regDst(d2RegDst), .ex_aluSrc(d2AluSrc),
        .ex_aluOp(d2AluOp), .mem_memRead(d2MemRead),
        .mem_memWrite(d2MemWrite), .mem_branch(d2Branch),
        .wb_memtoReg(d2MemtoReg), .wb_regWrite(d2RegWrite),
        .illegal_op(d2IllOp), .illegal_opcode(d2IllOpc),
        .illegal_cnt(d2Cnt)
    );

    typedef struct {
        string      tag;
        logic       stall;
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        logic       ill;
        logic [2:0] opc;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic stallS;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic checkZero(input string nm);
        chk({nm, ".ctl"}, 16'({ex_regDst, ex_aluSrc, ex_aluOp,
            mem_memRead, mem_memWrite, mem_branch,
            wb_memtoReg, wb_regWrite, hazard_stall}), 16'd0);
        chk({nm, ".ill"}, 16'({illegal_op, illegal_opcode}), 16'd0);
        chk({nm, ".cnt"}, 16'(illegal_cnt), 16'd0);
        chk({nm, ".cnt2"}, 16'({d2IllOp, d2Cnt}), 16'd0);
    endtask

    // Monitor: stall sampled mid-cycle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2 stallS = hazard_stall;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".stall"}, 16'(stallS), 16'(e.stall));
                chk({e.tag, ".ex"}, 16'({ex_regDst, ex_aluSrc, ex_aluOp}),
                    16'(e.ex));
                chk({e.tag, ".mem"},
                    16'({mem_memRead, mem_memWrite, mem_branch}),
                    16'(e.mem));
                chk({e.tag, ".wb"}, 16'({wb_memtoReg, wb_regWrite}),
                    16'(e.wb));
                chk({e.tag, ".ill"}, 16'({illegal_op, illegal_opcode}),
                    16'({e.ill, e.opc}));
                chk({e.tag, ".cnt"}, 16'(illegal_cnt), 16'(e.cnt));
                chk({e.tag, ".cnt2"}, 16'(d2Cnt), 16'(e.cnt2));
            end
        end
    end

    task automatic step(input string tag, input logic rstv,
                        input logic v, input logic [2:0] op,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input logic fl, input logic eStall,
                        input logic [3:0] eEx, input logic [2:0] eMem,
                        input logic [1:0] eWb, input logic eIll,
                        input logic [2:0] eOpc, input logic [7:0] eCnt,
                        input logic [1:0] eCnt2);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n     = rstv;
        valid_id  = v;
        opcode_id = op;
        rs_id     = rs;
        rt_id     = rt;
        flush_in  = fl;
        e = '{tag, eStall, eEx, eMem, eWb, eIll, eOpc, eCnt, eCnt2};
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b1; valid_id = 1'b0; flush_in = 1'b0;
        opcode_id = 3'd0; rs_id = 3'd0; rt_id = 3'd0;
        #1 rst_n = 1'b0;
        #2 checkZero("reset");

        // back-to-back decode
        step("A1",1,1,3'b000,3'd1,3'd2,0,0,4'b1000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("A2",1,1,3'b001,3'd1,3'd2,0,0,4'b0110,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("A3",1,1,3'b100,3'd1,3'd7,0,0,4'b0111,3'b000,2'b01,0,3'd0,8'd0,2'd0);
        step("A4",1,1,3'b101,3'd1,3'd2,0,0,4'b0111,3'b100,2'b01,0,3'd0,8'd0,2'd0);
        step("A5",1,1,3'b110,3'd1,3'd2,0,0,4'b0001,3'b010,2'b11,0,3'd0,8'd0,2'd0);
        step("A6",1,1,3'b111,3'd1,3'd2,0,0,4'b0111,3'b001,2'b00,0,3'd0,8'd0,2'd0);
        step("A7",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("A8",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b01,0,3'd0,8'd0,2'd0);
        step("A9",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);

        // load-use stall
        step("B1",1,1,3'b100,3'd0,3'd3,0,0,4'b0111,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("B2",1,1,3'b000,3'd3,3'd4,0,1,4'b0000,3'b100,2'b00,0,3'd0,8'd0,2'd0);
        step("B3",1,1,3'b000,3'd3,3'd4,0,0,4'b1000,3'b000,2'b11,0,3'd0,8'd0,2'd0);
        step("B4",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("B5",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b01,0,3'd0,8'd0,2'd0);
        step("B6",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);

        // branch flush in MEM
        step("C1",1,1,3'b110,3'd1,3'd2,0,0,4'b0001,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("C2",1,1,3'b000,3'd1,3'd2,0,0,4'b1000,3'b001,2'b00,0,3'd0,8'd0,2'd0);
        step("C3",1,1,3'b001,3'd1,3'd2,1,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("C4",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("C5",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        // flush masks stall and illegal tracking
        step("C6",1,1,3'b100,3'd1,3'd5,0,0,4'b0111,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("C7",1,1,3'b010,3'd5,3'd2,1,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("C8",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);

        // illegal opcodes and saturation of the 2-bit counter
        step("D1",1,1,3'b010,3'd1,3'd2,0,0,4'b0000,3'b000,2'b00,1,3'b010,8'd1,2'd1);
        step("D2",1,1,3'b011,3'd1,3'd2,0,0,4'b0000,3'b000,2'b00,1,3'b010,8'd2,2'd2);
        step("D3",1,1,3'b000,3'd1,3'd2,0,0,4'b1000,3'b000,2'b00,1,3'b010,8'd2,2'd2);
        step("D4",1,1,3'b010,3'd1,3'd2,0,0,4'b0000,3'b000,2'b00,1,3'b010,8'd3,2'd3);
        step("D5",1,1,3'b011,3'd1,3'd2,0,0,4'b0000,3'b000,2'b01,1,3'b010,8'd4,2'd3);
        step("D6",1,1,3'b010,3'd1,3'd2,0,0,4'b0000,3'b000,2'b00,1,3'b010,8'd5,2'd3);
        // illegal op held by a stall is not counted until accepted
        step("D7",1,1,3'b100,3'd1,3'd6,0,0,4'b0111,3'b000,2'b00,1,3'b010,8'd5,2'd3);
        step("D8",1,1,3'b011,3'd6,3'd2,0,1,4'b0000,3'b100,2'b00,1,3'b010,8'd5,2'd3);
        step("D9",1,1,3'b011,3'd6,3'd2,0,0,4'b0000,3'b000,2'b11,1,3'b010,8'd6,2'd3);
        step("DA",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,1,3'b010,8'd6,2'd3);

        // reset mid-stream with a load in MEM
        step("E1",1,1,3'b100,3'd0,3'd1,0,0,4'b0111,3'b000,2'b00,1,3'b010,8'd6,2'd3);
        step("E2",1,1,3'b000,3'd2,3'd2,0,0,4'b1000,3'b100,2'b00,1,3'b010,8'd6,2'd3);
        step("E3",0,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        #1 checkZero("asyncRst");
        step("E4",1,1,3'b100,3'd0,3'd1,0,0,4'b0111,3'b000,2'b00,0,3'd0,8'd0,2'd0);
        step("E5",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b100,2'b00,0,3'd0,8'd0,2'd0);
        step("E6",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b11,0,3'd0,8'd0,2'd0);
        step("E7",1,0,3'b000,3'd0,3'd0,0,0,4'b0000,3'b000,2'b00,0,3'd0,8'd0,2'd0);

        repeat (3) @(posedge clk);
        #2 chk("drain", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
